// File: rtl/comparator_pkg.sv
// Shared types and the 2-bit greater-than primitive for the serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    localparam int PAIR_W = 2;

    // x > y for unsigned 2-bit values: decide on the high bit, fall back to the low bit on a tie.
    function automatic logic pair_gt(input logic [PAIR_W-1:0] x, input logic [PAIR_W-1:0] y);
        return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    endfunction

endpackage

// File: rtl/two_bit_compare_slice.sv
// Combinational 2-bit compare slice; lt2 reuses the greater-than function with swapped operands.
module two_bit_compare_slice
    import comparator_pkg::*;
(
    input  logic [PAIR_W-1:0] a2,
    input  logic [PAIR_W-1:0] b2,
    output logic              gt2,
    output logic              lt2
);

    assign gt2 = pair_gt(a2, b2);
    assign lt2 = pair_gt(b2, a2);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Unsigned magnitude comparator scanning two bits per cycle, MSB pair first, with early exit
// on the first differing pair and valid/ready handshakes on both sides.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int PAIRS = WIDTH / PAIR_W;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

    cmp_state_e       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [CNT_W-1:0] cnt_reg;
    cmp_result_t      res_reg;
    logic             gt2;
    logic             lt2;

    two_bit_compare_slice u_slice (
        .a2  (a_sh_reg[WIDTH-1 -: PAIR_W]),
        .b2  (b_sh_reg[WIDTH-1 -: PAIR_W]),
        .gt2 (gt2),
        .lt2 (lt2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            cnt_reg   <= '0;
            res_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        cnt_reg   <= '0;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (gt2) begin
                        res_reg.gt <= 1'b1;
                        state_reg  <= DONE;
                    end else if (lt2) begin
                        res_reg.lt <= 1'b1;
                        state_reg  <= DONE;
                    end else if (cnt_reg == LAST_PAIR) begin
                        res_reg.eq <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        // Pairs so far are equal: bring the next lower pair to the top.
                        a_sh_reg  <= a_sh_reg << PAIR_W;
                        b_sh_reg  <= b_sh_reg << PAIR_W;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        res_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    res_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // in_ready is held low while reset is asserted so no handshake can complete against it.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign gt        = res_reg.gt;
    assign eq        = res_reg.eq;
    assign lt        = res_reg.lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and exhaustive checks of serial_magnitude_comparator at WIDTH=4 and WIDTH=8.
module tb_serial_magnitude_comparator;

    localparam int MAXLAT = 40;

    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] r;      // {gt, eq, lt}
        int         lat;
        int         stall;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel8;
    logic       iv;
    logic       ordy;
    logic [7:0] av;
    logic [7:0] bv;

    logic ir4, ov4, gt4, eq4, lt4;
    logic ir8, ov8, gt8, eq8, lt8;
    logic ir, ov, gt, eq, lt;

    int tests = 0;
    int fails = 0;

    serial_magnitude_comparator #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & ~sel8),
        .in_ready  (ir4),
        .a         (av[3:0]),
        .b         (bv[3:0]),
        .out_valid (ov4),
        .out_ready (ordy & ~sel8),
        .gt        (gt4),
        .eq        (eq4),
        .lt        (lt4)
    );

    serial_magnitude_comparator #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & sel8),
        .in_ready  (ir8),
        .a         (av),
        .b         (bv),
        .out_valid (ov8),
        .out_ready (ordy & sel8),
        .gt        (gt8),
        .eq        (eq8),
        .lt        (lt8)
    );

    assign ir = sel8 ? ir8 : ir4;
    assign ov = sel8 ? ov8 : ov4;
    assign gt = sel8 ? gt8 : gt4;
    assign eq = sel8 ? eq8 : eq4;
    assign lt = sel8 ? lt8 : lt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input int w, input logic [7:0] a_i, input logic [7:0] b_i);
        for (int k = 0; k < w / 2; k++) begin
            if (a_i[w-1-2*k -: 2] != b_i[w-1-2*k -: 2]) return k + 2;
        end
        return w / 2 + 1;
    endfunction

    // One full transaction; called at a negedge, returns at a negedge with the DUT idle.
    task automatic run_op(input int w, input logic [7:0] a_i, input logic [7:0] b_i,
                          input logic [2:0] exp_r, input int exp_lat, input int stall,
                          input string tag);
        int lat;
        int guard;
        logic [2:0] got;
        sel8 = (w == 8);
        ordy = 1'b0;
        guard = 0;
        while (!ir && guard < MAXLAT) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " in_ready_before_accept"}, 32'(ir), 32'd1);
        av = a_i;
        bv = b_i;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        av = 8'($urandom);
        bv = 8'($urandom);
        chk({tag, " in_ready_scan"}, 32'(ir), 32'd0);
        lat = 1;
        while (!ov && lat < MAXLAT) begin
            @(negedge clk);
            lat++;
        end
        got = {gt, eq, lt};
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, 32'(got), 32'(exp_r));
        for (int s = 0; s < stall; s++) begin
            if (s == 1) iv = 1'b1;
            @(negedge clk);
            iv = 1'b0;
            chk({tag, " hold_valid_result"}, 32'({ov, gt, eq, lt}), 32'({1'b1, exp_r}));
            chk({tag, " hold_in_ready"}, 32'(ir), 32'd0);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk({tag, " release_valid"}, 32'(ov), 32'd0);
        chk({tag, " release_in_ready"}, 32'(ir), 32'd1);
        chk({tag, " release_result"}, 32'({gt, eq, lt}), 32'd0);
        $display("[TB] %s w=%0d a=%h b=%h gt/eq/lt=%b lat=%0d stall=%0d",
                 tag, w, a_i, b_i, got, lat, stall);
    endtask

    vec_t vecs[12];

    initial begin
        int seen;
        logic [3:0] ea;
        logic [3:0] eb;

        vecs[0]  = '{4, 8'h0B, 8'h07, 3'b100, 2, 0};
        vecs[1]  = '{4, 8'h05, 8'h05, 3'b010, 3, 0};
        vecs[2]  = '{4, 8'h06, 8'h07, 3'b001, 3, 0};
        vecs[3]  = '{4, 8'h0B, 8'h07, 3'b100, 2, 5};
        vecs[4]  = '{4, 8'h00, 8'h00, 3'b010, 3, 1};
        vecs[5]  = '{4, 8'h0F, 8'h00, 3'b100, 2, 0};
        vecs[6]  = '{4, 8'h00, 8'h0F, 3'b001, 2, 2};
        vecs[7]  = '{8, 8'hA5, 8'hA5, 3'b010, 5, 0};
        vecs[8]  = '{8, 8'h00, 8'h01, 3'b001, 5, 0};
        vecs[9]  = '{8, 8'h80, 8'h7F, 3'b100, 2, 0};
        vecs[10] = '{8, 8'hFF, 8'hFE, 3'b100, 5, 3};
        vecs[11] = '{8, 8'h12, 8'h34, 3'b001, 3, 0};

        rst  = 1'b1;
        sel8 = 1'b0;
        iv   = 1'b0;
        ordy = 1'b0;
        av   = '0;
        bv   = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'({ir4, ir8}), 32'd0);
        chk("reset out_valid", 32'({ov4, ov8}), 32'd0);
        chk("reset results", 32'({gt4, eq4, lt4, gt8, eq8, lt8}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset in_ready", 32'({ir4, ir8}), 32'b11);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, vecs[i].stall,
                   $sformatf("vec%0d", i));
        end

        // Reset during a WIDTH=8 equal-operand scan must abandon the operation.
        sel8 = 1'b1;
        av = 8'h3C;
        bv = 8'h3C;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan in_ready_in_reset", 32'(ir), 32'd0);
        chk("midscan outputs_in_reset", 32'({ov, gt, eq, lt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midscan in_ready_after_reset", 32'(ir), 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov || gt || eq || lt) seen++;
            @(negedge clk);
        end
        chk("midscan no_result", 32'(seen), 32'd0);
        $display("[TB] midscan-reset w=8 a=3c b=3c abandoned");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                ea = 4'(ai);
                eb = 4'(bi);
                run_op(4, {4'h0, ea}, {4'h0, eb}, {ea > eb, ea == eb, ea < eb},
                       model_lat(4, {4'h0, ea}, {4'h0, eb}), int'($urandom_range(0, 2)),
                       "exh");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential magnitude comparator for the comparator datapath. It accepts two unsigned WIDTH-bit operands through a valid/ready handshake and scans them two bits per cycle, MSB pair first, using a 2-bit compare slice. It stops early at the first differing pair and returns a one-hot gt/eq/lt result through a second valid/ready handshake. It lets the fixed 2-bit greater-than logic serve wider operands without a wide combinational tree.

## Interface
- WIDTH, 4, operand width in bits; must be even and ≥ 2.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture a and b into shift registers, clear the pair counter to 0, and go to SCAN.
- SCAN:
  - in_ready = 0.
  - Each cycle, the slice compares the top pair a_sh[WIDTH-1:WIDTH-2] vs b_sh[WIDTH-1:WIDTH-2].
  - Slice reports gt2 when the A pair is greater and lt2 when the B pair is greater. Both are derived from the same greater-than function with operands swapped.
  - If gt2: register gt=1, go to DONE.
  - If lt2: register lt=1, go to DONE.
  - Else, if the counter equals WIDTH/2-1: register eq=1, go to DONE.
  - Else, shift both registers left by 2, increment the counter, and stay in SCAN.
- DONE:
  - out_valid = 1; gt/eq/lt are held stable.
  - On out_ready, clear gt/eq/lt and go to IDLE.
- Output rules:
  - Exactly one of gt/eq/lt is high while out_valid = 1; all are 0 otherwise.
  - out_valid never drops without out_ready.
- in_valid is ignored outside IDLE. The producer must hold its operands until it sees in_ready, so no data is lost.
- Counter width: $clog2(WIDTH/2), minimum 1 bit; it never wraps.

## Timing
- Reset (rst high at an edge):
  - state = IDLE; out_valid = 0; gt = eq = lt = 0; shift registers and counter cleared.
  - in_ready is forced to 0 while rst is high and is 1 in the first cycle after rst is low.
- Reset mid-SCAN or mid-DONE abandons the operation. No out_valid is produced for it.
- Latency, with operands accepted at the edge ending cycle N:
  - MSB pair evaluated in cycle N+1.
  - A decision at pair k (k = 0 is MSB) gives out_valid high from cycle N+k+2.
  - Best case: N+2. Equal operands: N+WIDTH/2+1.
- Result accepted at the edge ending cycle M gives out_valid = 0 and in_ready = 1 in cycle M+1. There is no overlap of operations.
- Simultaneous rst and a handshake: rst wins, and the handshake is not taken.
- in_ready, out_valid and gt/eq/lt are driven from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package comparator_pkg holds:
  - the cmp_state_e enum (IDLE, SCAN, DONE);
  - the cmp_result_t packed struct {gt, eq, lt};
  - localparam PAIR_W = 2.
- Sub-module two_bit_compare_slice: purely combinational, inputs a2[1:0] and b2[1:0], outputs gt2 and lt2. Instantiate it once.
- Top-level module: FSM, shift registers, counter and result register.

## Test plan
- WIDTH=4, a=4'b1011, b=4'b0111, out_ready=1 -> gt=1 with out_valid in cycle N+2 (early termination); in_ready back to 1 in N+3.
- WIDTH=4, a=4'd5, b=4'd5 -> eq=1, out_valid in N+3. Then a=4'b0110, b=4'b0111 -> lt=1, out_valid in N+3.
- Backpressure: with out_ready held low for 5 cycles after out_valid -> gt/eq/lt and out_valid remain stable. A new in_valid pulse during this time is not accepted (in_ready = 0). Raising out_ready -> out_valid = 0 next cycle.
- Reset mid-scan: WIDTH=8 with equal operands, rst asserted in cycle N+2 -> no out_valid ever appears for that operation, all outputs are 0, and in_ready = 1 the cycle after rst deasserts.
- WIDTH=8, a=8'hA5, b=8'hA5 -> eq at N+5; a=8'h00, b=8'h01 -> lt at N+5; a=8'h80, b=8'h7F -> gt at N+2.
- WIDTH=4 exhaustive check: all 256 (a, b) pairs with random out_ready stalls, compared against a reference model using >, == and <. Also check the one-hot rule and the latency formula on every result.
